p251_mul_issue: RTL and testbench

//  Request-side driver for the GF(251) reducer: accepts byte operand pairs (a,b), forms the
//  16-bit product a*b and issues it on the reducer's start/data interface (i_a/i_start).

---
 rtl/p251_mul_issue.sv | 180 ++++++++++++++++++
 tb/tb_p251_mul_issue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p251_mul_issue.sv
// p251_mul_issue: issues a*b to the GF(251) reducer and buffers reduced results in a credit-guarded FIFO.
// Latency accept->o_valid = 1 + RED_LAT + 1; o_ready drops when every FIFO slot is owed (credits = 0).
// Optional sticky error flag (bad operand / result into full FIFO) built only with P251_MUL_ISSUE_CHECK_EN.

module p251_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is dropped; the caller's credit scheme makes that a protocol violation.
  assign do_push  = push && !full;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module p251_mul_issue #(
  parameter int FIFO_DEPTH = 4,
  parameter int RED_LAT    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_op_a,
  input  logic [7:0]  i_op_b,
  output logic        o_ready,
  output logic [15:0] o_red_a,
  output logic        o_red_start,
  input  logic [7:0]  i_red_c,
  input  logic        i_red_done,
  output logic        o_valid,
  output logic [7:0]  o_c,
  input  logic        i_ready,
  output logic        o_err
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = $clog2(RED_LAT + 2);

  typedef enum logic {DRAIN, RUN} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] drain_cnt;
  logic [DW-1:0] drain_cnt_nxt;
  logic [CW-1:0] credits;
  logic          run;
  logic          accept;
  logic          pop;
  logic          red_push;
  logic          fifo_empty;
  logic          fifo_full;
  logic [7:0]    head_dat;

  assign run      = (state == RUN);
  assign o_ready  = run && (credits != '0);
  assign accept   = i_valid && o_ready;
  assign o_valid  = !fifo_empty;
  assign pop      = o_valid && i_ready;
  assign o_c      = fifo_empty ? 8'h00 : head_dat;
  // The reducer is not reset with us; results still in its pipe are ignored while draining.
  assign red_push = i_red_done && run;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= DRAIN;
      drain_cnt <= DW'(RED_LAT);
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Enter RUN on the edge where the counter reaches zero, so o_ready rises RED_LAT cycles after release.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      DRAIN: begin
        if (drain_cnt <= DW'(1)) state_nxt = RUN;
        if (drain_cnt != '0) drain_cnt_nxt = drain_cnt - DW'(1);
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = DRAIN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_red_a     <= '0;
      o_red_start <= 1'b0;
    end else begin
      o_red_start <= accept;
      if (accept) o_red_a <= {8'b0, i_op_a} * {8'b0, i_op_b};
    end
  end

  // One credit per FIFO slot: covers both products in flight and results already buffered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      credits <= CW'(FIFO_DEPTH);
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  p251_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .push     (red_push),
    .push_dat (i_red_c),
    .pop      (pop),
    .head_dat (head_dat),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

`ifdef P251_MUL_ISSUE_CHECK_EN
  logic op_bad;
  logic red_ovf;

  assign op_bad  = accept && ((i_op_a >= 8'd251) || (i_op_b >= 8'd251));
  assign red_ovf = red_push && fifo_full;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else if (op_bad || red_ovf) begin
      o_err <= 1'b1;
    end
  end
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_p251_mul_issue.sv
// Bench for p251_mul_issue: behavioural fixed-latency reducer plus a scoreboard of expected (a*b)%251.
`timescale 1ns/1ps
module tb_p251_mul_issue;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [7:0]  i_op_a;
  logic [7:0]  i_op_b;
  logic        o_ready;
  logic [15:0] o_red_a;
  logic        o_red_start;
  logic [7:0]  i_red_c;
  logic        i_red_done;
  logic        o_valid;
  logic [7:0]  o_c;
  logic        i_ready;
  logic        o_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic        exp_err;

  logic [LAT-1:0]       red_v = '0;
  logic [LAT-1:0][15:0] red_p = '0;
  logic                 inj_vld;
  logic [7:0]           inj_c;

  always #5 i_clk = ~i_clk;

  p251_mul_issue #(.FIFO_DEPTH(DEPTH), .RED_LAT(LAT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_op_a(i_op_a), .i_op_b(i_op_b),
    .o_ready(o_ready), .o_red_a(o_red_a), .o_red_start(o_red_start),
    .i_red_c(i_red_c), .i_red_done(i_red_done), .o_valid(o_valid), .o_c(o_c),
    .i_ready(i_ready), .o_err(o_err)
  );

  // Reducer model: never reset, result appears LAT cycles after the start strobe.
  always @(posedge i_clk) begin
    red_v[0] <= o_red_start;
    red_p[0] <= o_red_a;
    for (int k = 1; k < LAT; k++) begin
      red_v[k] <= red_v[k-1];
      red_p[k] <= red_p[k-1];
    end
  end
  assign i_red_done = red_v[LAT-1] | inj_vld;
  assign i_red_c    = inj_vld ? inj_c : 8'(red_p[LAT-1] % 16'd251);

  // Scoreboard: pops compared first so a same-cycle pop+accept never looks like an over-issue.
  always @(negedge i_clk) begin
    #2;
    if (!i_rst) begin
      if (o_valid && i_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL unexpected_result: got o_c=%0d, want no output", o_c);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (o_c !== e) begin n_fail++; $display("FAIL result_order: got %0d want %0d", o_c, e); end
        end
      end
      if (i_valid && o_ready) begin
        int p;
        p = i_op_a * i_op_b;
        exp_q.push_back(8'(p % 251));
        n_checks++;
        if (exp_q.size() > DEPTH) begin
          n_fail++; $display("FAIL credit_overrun: outstanding %0d want <= %0d", exp_q.size(), DEPTH);
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_valid = 1'b0;
    tick();
    exp_q.delete();
    i_rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok = 0;
    i_valid = 1'b1; i_op_a = a; i_op_b = b;
    for (int c = 0; c < 50; c++) begin
      if (o_ready) begin ok = 1; tick(); break; end
      tick();
    end
    if (!ok) begin n_checks++; n_fail++; $display("FAIL send_timeout: a=%0d b=%0d never accepted", a, b); end
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      if (o_valid) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin n_checks++; n_fail++; $display("FAIL valid_timeout: o_valid never rose"); end
  endtask

  task automatic test_reset();
    i_ready = 1'b0; i_rst = 1'b1; i_valid = 1'b0;
    tick();
    n_checks++; if (o_ready !== 1'b0)     begin n_fail++; $display("FAIL rst_o_ready: got %b want 0", o_ready); end
    n_checks++; if (o_red_start !== 1'b0) begin n_fail++; $display("FAIL rst_o_red_start: got %b want 0", o_red_start); end
    n_checks++; if (o_red_a !== 16'd0)    begin n_fail++; $display("FAIL rst_o_red_a: got %0d want 0", o_red_a); end
    n_checks++; if (o_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_o_valid: got %b want 0", o_valid); end
    n_checks++; if (o_c !== 8'd0)         begin n_fail++; $display("FAIL rst_o_c: got %0d want 0", o_c); end
    n_checks++; if (o_err !== 1'b0)       begin n_fail++; $display("FAIL rst_o_err: got %b want 0", o_err); end
    exp_q.delete();
    i_rst = 1'b0;
    tick();
    n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready_low: got %b want 0", o_ready); end
    tick();
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready_high: got %b want 1", o_ready); end
  endtask

  task automatic test_single();
    i_ready = 1'b0;
    send(8'd1, 8'd251);
    i_valid = 1'b0;
    n_checks++; if (o_red_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", o_red_start); end
    n_checks++; if (o_red_a !== 16'd251)  begin n_fail++; $display("FAIL single_red_a: got %0d want 251", o_red_a); end
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: cycle %0d got %b want 0", c + 1, o_valid); end
      if (c == 0) begin
        tick();
        n_checks++; if (o_red_start !== 1'b0) begin n_fail++; $display("FAIL single_strobe_len: got %b want 0", o_red_start); end
        n_checks++; if (o_red_a !== 16'd251)  begin n_fail++; $display("FAIL single_red_a_hold: got %0d want 251", o_red_a); end
      end else tick();
    end
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: got o_valid=%b want 1", o_valid); end
    n_checks++; if (o_c !== 8'd0)     begin n_fail++; $display("FAIL single_o_c: got %0d want 0", o_c); end
    n_checks++; if (o_err !== 1'b0)   begin n_fail++; $display("FAIL single_o_err: got %b want 0", o_err); end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop: got o_valid=%b want 0", o_valid); end
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b1;
    send(8'd128, 8'd128);
    n_checks++; if (o_red_start !== 1'b1 || o_red_a !== 16'd16384) begin n_fail++; $display("FAIL b2b_first: got start=%b a=%0d want 1/16384", o_red_start, o_red_a); end
    send(8'd255, 8'd255);
    i_valid = 1'b0;
    n_checks++; if (o_red_start !== 1'b1 || o_red_a !== 16'd65025) begin n_fail++; $display("FAIL b2b_second: got start=%b a=%0d want 1/65025", o_red_start, o_red_a); end
    tick();
    n_checks++; if (o_red_start !== 1'b0) begin n_fail++; $display("FAIL b2b_strobe_end: got %b want 0", o_red_start); end
    wait_valid();
    n_checks++; if (o_c !== 8'd69) begin n_fail++; $display("FAIL b2b_c0: got %0d want 69", o_c); end
    tick();
    n_checks++; if (o_valid !== 1'b1 || o_c !== 8'd16) begin n_fail++; $display("FAIL b2b_c1: got v=%b c=%0d want 1/16", o_valid, o_c); end
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b want 0", o_valid); end
  endtask

  task automatic test_full();
    i_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(8'(10 + i), 8'(20 + i));
    i_op_a = 8'd50; i_op_b = 8'd3;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: cycle %0d got %b want 0", c, o_ready); end
      tick();
    end
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b want 1", o_valid); end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL credit_return: got %b want 1", o_ready); end
    tick();
    i_valid = 1'b0;
    n_checks++; if (o_red_start !== 1'b1 || o_red_a !== 16'd150) begin n_fail++; $display("FAIL fifth_issue: got start=%b a=%0d want 1/150", o_red_start, o_red_a); end
    i_ready = 1'b1;
    for (int c = 0; c < 40 && (exp_q.size() != 0 || o_valid); c++) tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_drain: %0d results missing, want 0", exp_q.size()); end
    i_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b1;
    send(8'd7, 8'd9);
    send(8'd11, 8'd13);
    i_valid = 1'b0;
    do_reset();
    n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_c1: got %b want 0", o_ready); end
    tick();
    n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_c2: got %b want 0", o_ready); end
    tick();
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_c3: got %b want 1", o_ready); end
    for (int c = 0; c < 6; c++) begin
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_discard: cycle %0d got o_valid=%b want 0", c, o_valid); end
      tick();
    end
  endtask

  task automatic test_check();
    do_reset();
    i_ready = 1'b0;
    send(8'd251, 8'd1);
    i_valid = 1'b0;
    wait_valid();
    n_checks++; if (o_c !== 8'd0)     begin n_fail++; $display("FAIL chk_o_c: got %0d want 0", o_c); end
    n_checks++; if (o_err !== exp_err) begin n_fail++; $display("FAIL chk_err_set: got %b want %b", o_err, exp_err); end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    n_checks++; if (o_err !== exp_err) begin n_fail++; $display("FAIL chk_err_sticky: got %b want %b", o_err, exp_err); end
    do_reset();
    n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL chk_err_reset: got %b want 0", o_err); end
  endtask

  task automatic test_protocol();
    do_reset();
    i_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(8'(2 + 2 * i), 8'(3 + 2 * i));
    i_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL proto_err_pre: got %b want 0", o_err); end
    inj_c = 8'hAA; inj_vld = 1'b1;
    tick();
    inj_vld = 1'b0;
    n_checks++; if (o_err !== exp_err) begin n_fail++; $display("FAIL proto_err: got %b want %b", o_err, exp_err); end
    n_checks++; if (o_ready !== 1'b0)  begin n_fail++; $display("FAIL proto_ready: got %b want 0", o_ready); end
    i_ready = 1'b1;
    for (int c = 0; c < DEPTH; c++) tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL proto_dropped: got o_valid=%b want 0", o_valid); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL proto_credits: got o_ready=%b want 1", o_ready); end
    i_ready = 1'b0;
  endtask

  task automatic test_random();
    int acc;
    int cyc;
    acc = 0; cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_op_a  = 8'($urandom_range(0, 255));
      i_op_b  = 8'($urandom_range(0, 255));
      i_ready = ($urandom_range(0, 2) != 0);
      if (i_valid && o_ready) acc++;
      tick();
      cyc++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 40 && (exp_q.size() != 0 || o_valid); c++) tick();
    n_checks++; if (acc != 1000) begin n_fail++; $display("FAIL rand_accepts: got %0d want 1000", acc); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: %0d results missing, want 0", exp_q.size()); end
    i_ready = 1'b0;
  endtask

  initial begin
`ifdef P251_MUL_ISSUE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    i_rst = 1'b1; i_valid = 1'b0; i_op_a = '0; i_op_b = '0; i_ready = 1'b0;
    inj_vld = 1'b0; inj_c = '0;
    @(negedge i_clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_check();
    test_protocol();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
